out_monitor: RTL

- Downstream checker for the N/M burst state machine; consumes its Running, OUT and BIS_END outputs.
- Measures each OUT high pulse and counts the pulses in one burst.
- Compares the results against the expected high-time and pulse count.
- Presents a latched pass/fail report through a done/ack handshake for the test controller.

---
 rtl/out_monitor_if.sv | 29 ++
 rtl/out_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/out_monitor_if.sv
// Bus between the N/M burst state machine, the out_monitor checker and the
// test controller: the monitored burst signals plus the latched report.
interface out_monitor_if #(
    parameter int CW = 8,
    parameter int PW = 5
);
    logic          running;
    logic          out_in;
    logic          bis_end;
    logic          ack;
    logic          done;
    logic          pass;
    logic [2:0]    err;
    logic [PW-1:0] pulse_count;
    logic [CW-1:0] min_high;
    logic [CW-1:0] max_high;

    // Stimulus / controller side.
    modport master (
        output running, out_in, bis_end, ack,
        input  done, pass, err, pulse_count, min_high, max_high
    );

    // Checker side.
    modport slave (
        input  running, out_in, bis_end, ack,
        output done, pass, err, pulse_count, min_high, max_high
    );
endinterface

// File: rtl/out_monitor.sv
// Burst checker: measures every OUT high pulse and counts the pulses of one
// burst, then latches a pass/fail report held until the controller acks it.
module out_monitor #(
    parameter int EXP_HIGH   = 6,
    parameter int EXP_PULSES = 13,
    parameter int CW         = 8,
    parameter int PW         = 5
) (
    input  logic         clk,
    input  logic         reset,
    out_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    localparam logic [CW-1:0] EXP_HIGH_W   = CW'(EXP_HIGH);
    localparam logic [PW-1:0] EXP_PULSES_W = PW'(EXP_PULSES);

    state_t        state_q, state_d;
    logic          run_q, out_q;
    logic [CW-1:0] high_len_q, high_len_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [2:0]    err_q, err_d;
    logic [PW-1:0] count_q, count_d;
    logic [CW-1:0] min_q, min_d;
    logic [CW-1:0] max_q, max_d;

    logic          arm, burst_end, abort, close;
    logic [CW-1:0] high_inc, close_len;

    // Event decode shared by the next-state and output logic.
    assign arm       = (state_q == IDLE) && bus.running && !run_q;
    assign burst_end = (state_q == MEASURE) && bus.bis_end;
    // A running fall coinciding with bis_end is a normal end, not an abort.
    assign abort     = (state_q == MEASURE) && !bus.running && run_q && !bus.bis_end;
    // A pulse closes on its falling edge, or on bis_end while still high.
    assign close     = (state_q == MEASURE) &&
                       ((out_q && !bus.out_in) || (bus.bis_end && bus.out_in));
    assign high_inc  = (high_len_q == '1) ? high_len_q : high_len_q + CW'(1);
    assign close_len = (bus.bis_end && bus.out_in) ? high_inc : high_len_q;

    // State register.
    // NOTE: reset is synchronous here, so it only lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: a default assignment first keeps every comb block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = MEASURE;
            MEASURE: if (burst_end || abort) state_d = REPORT;
            REPORT:  if (bus.ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the measurement and report registers.
    always_comb begin
        high_len_d = high_len_q;
        pass_d     = pass_q;
        err_d      = err_q;
        count_d    = count_q;
        min_d      = min_q;
        max_d      = max_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    err_d      = '0;
                    pass_d     = 1'b0;
                    count_d    = '0;
                    max_d      = '0;
                    min_d      = '1;
                    high_len_d = bus.out_in ? CW'(1) : '0;
                end
            end
            MEASURE: begin
                if (close)           high_len_d = '0;
                else if (bus.out_in) high_len_d = high_inc;
                if (close) begin
                    count_d = (count_q == '1) ? count_q : count_q + PW'(1);
                    if (close_len < min_q)      min_d    = close_len;
                    if (close_len > max_q)      max_d    = close_len;
                    if (close_len != EXP_HIGH_W) err_d[0] = 1'b1;
                end
                if (burst_end) begin
                    err_d[1] = (count_d != EXP_PULSES_W);
                    pass_d   = !err_d[0] && !err_d[1];
                end else if (abort) begin
                    err_d[2] = 1'b1;
                    pass_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign done_d = (state_d == REPORT);

    // Datapath and report registers, plus the input history.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q      <= 1'b0;
            out_q      <= 1'b0;
            high_len_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            count_q    <= '0;
            min_q      <= '0;
            max_q      <= '0;
        end else begin
            run_q      <= bus.running;
            out_q      <= bus.out_in;
            high_len_q <= high_len_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            count_q    <= count_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.err         = err_q;
    assign bus.pulse_count = count_q;
    assign bus.min_high    = min_q;
    assign bus.max_high    = max_q;
endmodule
